// File: rtl/flappy_ctrl_pkg.sv
// Shared types and default constants for the Flappy game sequencer.
package flappy_ctrl_pkg;

    localparam int SCORE_W = 4;

    localparam int DEF_DEBOUNCE_CYC = 500_000;
    localparam int DEF_PIPE_DIV     = 1_048_576;
    localparam int DEF_PHYS_DIV     = 2_097_152;
    localparam int DEF_FLASH_DIV    = 8_388_608;
    localparam int DEF_READY_CYC    = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_PLAY  = 2'd2,
        ST_LOSE  = 2'd3
    } game_state_t;

    // Width of a counter that runs 0..n-1; every divisor is at least 2.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Sequencer bus: raw buttons, collision and score in; strobes, ticks and status out.
interface flappy_game_ctrl_if;
    import flappy_ctrl_pkg::*;

    logic               btn_start;
    logic               btn_jump;
    logic               lose;
    logic [SCORE_W-1:0] score_in;
    logic               start_o;
    logic               ack_o;
    logic               run_o;
    logic               pipe_tick;
    logic               phys_tick;
    logic               jump_o;
    logic               flash_o;
    logic [1:0]         state_o;
    logic [SCORE_W-1:0] high_score;

    modport master (
        input  btn_start, btn_jump, lose, score_in,
        output start_o, ack_o, run_o, pipe_tick, phys_tick, jump_o, flash_o,
               state_o, high_score
    );

    modport slave (
        output btn_start, btn_jump, lose, score_in,
        input  start_o, ack_o, run_o, pipe_tick, phys_tick, jump_o, flash_o,
               state_o, high_score
    );

endinterface

// File: rtl/flappy_game_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle press pulse
// on the rising edge of the debounced level.
module btn_debounce
    import flappy_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int            CNT_W  = cnt_w(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            // Any sample that agrees with the accepted level restarts the count.
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_TC) begin
                    r_deb <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: debounced buttons, IDLE/READY/PLAY/LOSE FSM and tick enables.
// Define FLAPPY_HIGH_SCORE_EN to keep a best-score register; otherwise high_score is 0.
//   state    | meaning
//   ST_IDLE  | waiting for start press
//   ST_READY | get-ready delay of READY_CYC cycles
//   ST_PLAY  | running: ticks, jumps, collision watch
//   ST_LOSE  | flashing until start press acknowledges
module flappy_game_ctrl
    import flappy_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int PIPE_DIV     = DEF_PIPE_DIV,
    parameter int PHYS_DIV     = DEF_PHYS_DIV,
    parameter int FLASH_DIV    = DEF_FLASH_DIV,
    parameter int READY_CYC    = DEF_READY_CYC
) (
    input  logic                board_clk,
    input  logic                Reset,
    flappy_game_ctrl_if.master  bus
);

    localparam int PIPE_W  = cnt_w(PIPE_DIV);
    localparam int PHYS_W  = cnt_w(PHYS_DIV);
    localparam int FLASH_W = cnt_w(FLASH_DIV);
    localparam int READY_W = cnt_w(READY_CYC);

    localparam logic [PIPE_W-1:0]  PIPE_TC  = PIPE_W'(PIPE_DIV - 1);
    localparam logic [PHYS_W-1:0]  PHYS_TC  = PHYS_W'(PHYS_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_TC = FLASH_W'(FLASH_DIV - 1);
    localparam logic [READY_W-1:0] READY_TC = READY_W'(READY_CYC - 1);

    logic w_start_press;
    logic w_jump_press;

    game_state_t        r_state;
    logic               r_start;
    logic               r_ack;
    logic               r_run;
    logic               r_pipe_tick;
    logic               r_phys_tick;
    logic               r_jump;
    logic               r_flash;
    logic [PIPE_W-1:0]  r_pipe_cnt;
    logic [PHYS_W-1:0]  r_phys_cnt;
    logic [FLASH_W-1:0] r_flash_cnt;
    logic [READY_W-1:0] r_ready_cnt;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .board_clk (board_clk),
        .Reset     (Reset),
        .i_btn     (bus.btn_start),
        .o_press   (w_start_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_jump (
        .board_clk (board_clk),
        .Reset     (Reset),
        .i_btn     (bus.btn_jump),
        .o_press   (w_jump_press)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_ack       <= 1'b0;
            r_run       <= 1'b0;
            r_pipe_tick <= 1'b0;
            r_phys_tick <= 1'b0;
            r_jump      <= 1'b0;
            r_flash     <= 1'b0;
            r_pipe_cnt  <= '0;
            r_phys_cnt  <= '0;
            r_flash_cnt <= '0;
            r_ready_cnt <= '0;
        end else begin
            r_start     <= 1'b0;
            r_ack       <= 1'b0;
            r_pipe_tick <= 1'b0;
            r_phys_tick <= 1'b0;
            r_jump      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_press) begin
                        r_start     <= 1'b1;
                        r_ready_cnt <= '0;
                        r_state     <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (r_ready_cnt == READY_TC) begin
                        r_run      <= 1'b1;
                        r_pipe_cnt <= '0;
                        r_phys_cnt <= '0;
                        r_state    <= ST_PLAY;
                    end else begin
                        r_ready_cnt <= r_ready_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Ticks are emitted even on the cycle a collision ends the round.
                    r_pipe_tick <= (r_pipe_cnt == PIPE_TC);
                    r_phys_tick <= (r_phys_cnt == PHYS_TC);
                    r_pipe_cnt  <= (r_pipe_cnt == PIPE_TC) ? '0 : r_pipe_cnt + 1'b1;
                    r_phys_cnt  <= (r_phys_cnt == PHYS_TC) ? '0 : r_phys_cnt + 1'b1;
                    if (bus.lose) begin
                        r_run       <= 1'b0;
                        r_flash     <= 1'b0;
                        r_flash_cnt <= '0;
                        r_state     <= ST_LOSE;
                    end else begin
                        r_jump <= w_jump_press;
                    end
                end
                ST_LOSE: begin
                    if (w_start_press) begin
                        r_ack   <= 1'b1;
                        r_flash <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_flash_cnt == FLASH_TC) begin
                        r_flash     <= ~r_flash;
                        r_flash_cnt <= '0;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FLAPPY_HIGH_SCORE_EN
    logic               r_hs_pend;
    logic [SCORE_W-1:0] r_high_score;

    // Compare one cycle after the PLAY->LOSE transition so the final score has settled.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_hs_pend    <= 1'b0;
            r_high_score <= '0;
        end else begin
            r_hs_pend <= (r_state == ST_PLAY) && bus.lose;
            if (r_hs_pend && (bus.score_in > r_high_score)) begin
                r_high_score <= bus.score_in;
            end
        end
    end

    assign bus.high_score = r_high_score;
`else
    logic w_unused_score;

    assign w_unused_score = ^bus.score_in;
    assign bus.high_score = '0;
`endif

    assign bus.start_o   = r_start;
    assign bus.ack_o     = r_ack;
    assign bus.run_o     = r_run;
    assign bus.pipe_tick = r_pipe_tick;
    assign bus.phys_tick = r_phys_tick;
    assign bus.jump_o    = r_jump;
    assign bus.flash_o   = r_flash;
    assign bus.state_o   = r_state;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with small divisors; follows FLAPPY_HIGH_SCORE_EN.
module tb_flappy_game_ctrl;

    logic board_clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

`ifdef FLAPPY_HIGH_SCORE_EN
    localparam logic [3:0] EXP_HS = 4'd9;
`else
    localparam logic [3:0] EXP_HS = 4'd0;
`endif

    flappy_game_ctrl_if bus ();

    flappy_game_ctrl #(
        .DEBOUNCE_CYC (4),
        .PIPE_DIV     (8),
        .PHYS_DIV     (12),
        .FLASH_DIV    (16),
        .READY_CYC    (20)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.state_o !== 2'd0) begin
            bad++; $display("FAIL reset_state actual=%0d required=0", bus.state_o);
        end
        total++;
        if ({bus.start_o, bus.ack_o, bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o, bus.flash_o} !== 7'b0) begin
            bad++; $display("FAIL reset_outputs actual=%b required=0000000",
                {bus.start_o, bus.ack_o, bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o, bus.flash_o});
        end
        total++;
        if (bus.high_score !== 4'd0) begin
            bad++; $display("FAIL reset_high_score actual=%0d required=0", bus.high_score);
        end
        Reset = 1'b0;
        repeat (2) tick();
        total++;
        if (bus.state_o !== 2'd0) begin
            bad++; $display("FAIL post_reset_state actual=%0d required=0", bus.state_o);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            bus.btn_start = ((i / 2) % 2) == 0;
            tick();
            total++;
            if (bus.start_o !== 1'b0 || bus.state_o !== 2'd0) begin
                bad++; $display("FAIL bounce cyc=%0d start_o=%b state=%0d required 0/0", i, bus.start_o, bus.state_o);
            end
        end
        bus.btn_start = 1'b0;
        repeat (8) tick();
        total++;
        if (bus.state_o !== 2'd0) begin
            bad++; $display("FAIL bounce_settle state actual=%0d required=0", bus.state_o);
        end
    endtask

    // Ends in the cycle run_o first rises.
    task automatic test_start_to_play();
        int first_start = -1;
        int start_cnt   = 0;
        int first_run   = -1;
        bus.btn_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.start_o === 1'b1) begin
                if (first_start < 0) first_start = i;
                start_cnt++;
            end
            if (i == 7) begin
                total++;
                if (bus.state_o !== 2'd1) begin
                    bad++; $display("FAIL start_state_ready actual=%0d required=1", bus.state_o);
                end
            end
            if (i == 26) begin
                total++;
                if (bus.state_o !== 2'd1 || bus.run_o !== 1'b0) begin
                    bad++; $display("FAIL ready_hold state=%0d run=%b required 1/0", bus.state_o, bus.run_o);
                end
            end
            if (i == 10) bus.btn_start = 1'b0;
            if (bus.run_o === 1'b1) begin
                first_run = i;
                break;
            end
        end
        total++;
        if (first_start != 7) begin
            bad++; $display("FAIL start_latency actual=%0d required=7", first_start);
        end
        total++;
        if (start_cnt != 1) begin
            bad++; $display("FAIL start_width actual=%0d required=1", start_cnt);
        end
        total++;
        if (first_run != 27) begin
            bad++; $display("FAIL run_rise actual=%0d required=27", first_run);
        end
        total++;
        if (bus.state_o !== 2'd2) begin
            bad++; $display("FAIL play_state actual=%0d required=2", bus.state_o);
        end
    endtask

    task automatic test_ticks();
        logic exp_pipe;
        logic exp_phys;
        for (int j = 1; j <= 50; j++) begin
            tick();
            exp_pipe = (j % 8) == 0;
            exp_phys = (j % 12) == 0;
            total++;
            if (bus.pipe_tick !== exp_pipe) begin
                bad++; $display("FAIL pipe_tick j=%0d actual=%b required=%b", j, bus.pipe_tick, exp_pipe);
            end
            total++;
            if (bus.phys_tick !== exp_phys) begin
                bad++; $display("FAIL phys_tick j=%0d actual=%b required=%b", j, bus.phys_tick, exp_phys);
            end
            total++;
            if (bus.run_o !== 1'b1) begin
                bad++; $display("FAIL run_in_play j=%0d actual=%b required=1", j, bus.run_o);
            end
        end
    endtask

    task automatic test_jump_in_play();
        int first_jump = -1;
        int jump_cnt   = 0;
        int start_seen = 0;
        int not_play   = 0;
        bus.btn_jump  = 1'b1;
        bus.btn_start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.jump_o === 1'b1) begin
                if (first_jump < 0) first_jump = i;
                jump_cnt++;
            end
            if (bus.start_o === 1'b1) start_seen++;
            if (bus.state_o !== 2'd2) not_play++;
        end
        total++;
        if (first_jump != 7) begin
            bad++; $display("FAIL jump_latency actual=%0d required=7", first_jump);
        end
        total++;
        if (jump_cnt != 1) begin
            bad++; $display("FAIL jump_width actual=%0d required=1", jump_cnt);
        end
        total++;
        if (start_seen != 0 || not_play != 0) begin
            bad++; $display("FAIL start_in_play start_pulses=%0d off_play=%0d required 0/0", start_seen, not_play);
        end
        bus.btn_jump  = 1'b0;
        bus.btn_start = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_lose_and_jump();
        bus.btn_jump = 1'b1;
        repeat (7) tick();
        bus.lose     = 1'b1;
        bus.score_in = 4'd9;
        tick();
        total++;
        if (bus.jump_o !== 1'b0) begin
            bad++; $display("FAIL lose_beats_jump jump_o actual=%b required=0", bus.jump_o);
        end
        total++;
        if (bus.state_o !== 2'd3) begin
            bad++; $display("FAIL lose_state actual=%0d required=3", bus.state_o);
        end
        total++;
        if (bus.run_o !== 1'b0 || bus.flash_o !== 1'b0) begin
            bad++; $display("FAIL lose_entry run=%b flash=%b required 0/0", bus.run_o, bus.flash_o);
        end
    endtask

    task automatic test_lose_flash();
        logic exp_flash;
        bus.btn_jump = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_flash = (k >= 16) && (k < 32);
            total++;
            if (bus.flash_o !== exp_flash) begin
                bad++; $display("FAIL flash k=%0d actual=%b required=%b", k, bus.flash_o, exp_flash);
            end
            total++;
            if ({bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o} !== 4'b0 || bus.state_o !== 2'd3) begin
                bad++; $display("FAIL lose_quiet k=%0d rpfj=%b state=%0d required 0000/3", k,
                    {bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o}, bus.state_o);
            end
            if (k == 1) begin
                total++;
                if (bus.high_score !== EXP_HS) begin
                    bad++; $display("FAIL high_score_load actual=%0d required=%0d", bus.high_score, EXP_HS);
                end
            end
        end
    endtask

    task automatic test_ack();
        int first_ack = -1;
        int ack_cnt   = 0;
        int start_cnt = 0;
        bus.btn_start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.ack_o === 1'b1) begin
                if (first_ack < 0) first_ack = i;
                ack_cnt++;
            end
            if (bus.start_o === 1'b1) start_cnt++;
            if (i == 6) begin
                total++;
                if (bus.state_o !== 2'd3) begin
                    bad++; $display("FAIL ack_pre_state actual=%0d required=3", bus.state_o);
                end
            end
            if (i == 7) begin
                total++;
                if (bus.state_o !== 2'd0 || bus.flash_o !== 1'b0) begin
                    bad++; $display("FAIL ack_idle state=%0d flash=%b required 0/0", bus.state_o, bus.flash_o);
                end
            end
        end
        total++;
        if (first_ack != 7 || ack_cnt != 1) begin
            bad++; $display("FAIL ack_pulse first=%0d count=%0d required 7/1", first_ack, ack_cnt);
        end
        total++;
        if (start_cnt != 0 || bus.state_o !== 2'd0) begin
            bad++; $display("FAIL ack_no_restart start_pulses=%0d state=%0d required 0/0", start_cnt, bus.state_o);
        end
        bus.btn_start = 1'b0;
        bus.lose      = 1'b0;
        repeat (10) tick();
    endtask

    // Presses start from IDLE and advances until run_o rises; n = -1 if it never does.
    task automatic go_play(output int n);
        n = -1;
        bus.btn_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 10) bus.btn_start = 1'b0;
            if (bus.run_o === 1'b1) begin
                n = i;
                break;
            end
        end
        bus.btn_start = 1'b0;
    endtask

    task automatic test_round2();
        int n;
        go_play(n);
        total++;
        if (n != 27) begin
            bad++; $display("FAIL round2_run_rise actual=%0d required=27", n);
        end
        bus.score_in = 4'd5;
        bus.lose     = 1'b1;
        tick();
        tick();
        total++;
        if (bus.state_o !== 2'd3) begin
            bad++; $display("FAIL round2_lose_state actual=%0d required=3", bus.state_o);
        end
        total++;
        if (bus.high_score !== EXP_HS) begin
            bad++; $display("FAIL high_score_keep actual=%0d required=%0d", bus.high_score, EXP_HS);
        end
        bus.lose      = 1'b0;
        bus.btn_start = 1'b1;
        repeat (10) tick();
        total++;
        if (bus.state_o !== 2'd0) begin
            bad++; $display("FAIL round2_ack_state actual=%0d required=0", bus.state_o);
        end
        bus.btn_start = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int stale = 0;
        go_play(n);
        total++;
        if (n != 27) begin
            bad++; $display("FAIL round3_run_rise actual=%0d required=27", n);
        end
        bus.btn_jump = 1'b1;
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        total++;
        if (bus.state_o !== 2'd0 || bus.high_score !== 4'd0) begin
            bad++; $display("FAIL mid_reset_state state=%0d hs=%0d required 0/0", bus.state_o, bus.high_score);
        end
        total++;
        if ({bus.start_o, bus.ack_o, bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o, bus.flash_o} !== 7'b0) begin
            bad++; $display("FAIL mid_reset_outputs actual=%b required=0000000",
                {bus.start_o, bus.ack_o, bus.run_o, bus.pipe_tick, bus.phys_tick, bus.jump_o, bus.flash_o});
        end
        bus.btn_jump = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.jump_o !== 1'b0 || bus.start_o !== 1'b0 || bus.state_o !== 2'd0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++; $display("FAIL stale_press cycles_with_activity actual=%0d required=0", stale);
        end
    endtask

    initial begin
        Reset         = 1'b1;
        bus.btn_start = 1'b0;
        bus.btn_jump  = 1'b0;
        bus.lose      = 1'b0;
        bus.score_in  = 4'd0;
        test_reset();
        test_bounce();
        test_start_to_play();
        test_ticks();
        test_jump_in_play();
        test_lose_and_jump();
        test_lose_flash();
        test_ack();
        test_round2();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
